// File: rtl/edge_detector_pkg.sv
// Shared constants for the CAN RX edge detector.
package edge_detector_pkg;

  localparam logic RECESSIVE_LEVEL     = 1'b1;
  localparam int   SYNC_STAGES_DEFAULT = 2;
  localparam int   FILTER_LEN_DEFAULT  = 3;
  localparam int   SYNC_STAGES_MIN     = 2;
  localparam int   SYNC_STAGES_MAX     = 4;
  localparam int   FILTER_LEN_MIN      = 2;
  localparam int   FILTER_LEN_MAX      = 15;
  // Mismatch counter only needs to reach FILTER_LEN-1.
  localparam int   CNT_W               = $clog2(FILTER_LEN_MAX + 1);

endpackage

// File: rtl/edge_detector_sync.sv
// Multi-flop synchroniser for an asynchronous level; all flops reset to RST_VAL.
module edge_detector_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic signal_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the raw input through the chain; bit 0 is the metastability catcher.
  always_ff @(posedge clock) begin
    if (!reset_n) chain_q <= {SYNC_STAGES{RST_VAL}};
    else          chain_q <= {chain_q[SYNC_STAGES-2:0], signal_i};
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/edge_detector.sv
// CAN RX edge detector: synchroniser, optional glitch filter, registered
// rising/falling/any edge pulses. Optional filter enabled by defining
// EDGE_DETECTOR_GLITCH_FILTER_EN.
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int FILTER_LEN  = FILTER_LEN_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic signal_in,
  output logic edge_detected,
  output logic rising_edge,
  output logic falling_edge
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("edge_detector: SYNC_STAGES out of range");
  end
  if (FILTER_LEN < FILTER_LEN_MIN || FILTER_LEN > FILTER_LEN_MAX) begin : g_bad_filt
    $error("edge_detector: FILTER_LEN out of range");
  end

  logic sync_lvl;
  logic lvl;
  logic prev_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic any_q,  any_d;

  edge_detector_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (RECESSIVE_LEVEL)
  ) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .signal_i (signal_in),
    .sync_o   (sync_lvl)
  );

`ifdef EDGE_DETECTOR_GLITCH_FILTER_EN
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after FILTER_LEN consecutive mismatching cycles.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_lvl != lvl_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) lvl_d = sync_lvl;
      else                                 cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lvl_q <= RECESSIVE_LEVEL;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync_lvl;
`endif

  // Edge decode against the previous level; rise and fall are exclusive.
  always_comb begin
    rise_d = lvl & ~prev_q;
    fall_d = ~lvl & prev_q;
    any_d  = lvl ^ prev_q;
  end

  // Previous level and registered one-cycle pulses; reset drops any pending edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q <= RECESSIVE_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      any_q  <= 1'b0;
    end else begin
      prev_q <= lvl;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q  <= any_d;
    end
  end

  assign rising_edge   = rise_q;
  assign falling_edge  = fall_q;
  assign edge_detected = any_q;

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: history-based reference model checked
// every cycle, plus directed literal-latency checks and randomized stimulus.
module tb_edge_detector;

  localparam int SYNC = 2;
  localparam int FLEN = 3;
`ifdef EDGE_DETECTOR_GLITCH_FILTER_EN
  localparam int LAT  = SYNC + FLEN + 1;
  localparam int HOLD = FLEN;
`else
  localparam int LAT  = SYNC + 1;
  localparam int HOLD = 2;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic signal_in = 1'b1;
  logic edge_detected, rising_edge, falling_edge;

  int checks = 0;
  int errors = 0;

  edge_detector #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .signal_in     (signal_in),
    .edge_detected (edge_detected),
    .rising_edge   (rising_edge),
    .falling_edge  (falling_edge)
  );

  always #5 clock = ~clock;

  // Reference model: hist[0] is the input seen at the latest edge. The
  // synchronised level after an edge is the sample SYNC-1 edges older; the
  // filtered level flips once the last FLEN synchronised samples all disagree.
  bit hist [32];
  bit mlvl = 1'b1, mprev = 1'b1, er = 1'b0, ef = 1'b0, started = 1'b0;

  always @(posedge clock) begin
    bit newl, flip;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) hist[i] = 1'b1;
      mlvl = 1'b1; mprev = 1'b1; er = 1'b0; ef = 1'b0; started = 1'b1;
    end else begin
      for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = signal_in;
`ifdef EDGE_DETECTOR_GLITCH_FILTER_EN
      flip = 1'b1;
      for (int j = 0; j < FLEN; j++) if (hist[SYNC+j] == mlvl) flip = 1'b0;
      newl = flip ? ~mlvl : mlvl;
`else
      flip = 1'b0;
      newl = hist[SYNC-1];
`endif
      er = mlvl & ~mprev;
      ef = ~mlvl & mprev;
      mprev = mlvl;
      mlvl  = newl;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (started) begin
      chk("model_rise", rising_edge, er);
      chk("model_fall", falling_edge, ef);
      chk("model_any", edge_detected, er | ef);
    end
  end

  task automatic quiet(input string nm, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      chk({nm, "_rise"}, rising_edge, 1'b0);
      chk({nm, "_fall"}, falling_edge, 1'b0);
      chk({nm, "_any"}, edge_detected, 1'b0);
    end
  endtask

  initial begin
    int run;
    bit lv;
    // Reset with bus idle high: nothing after release.
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    quiet("rst_idle", 10);

    // Falling edge: pulse exactly LAT edges after the first sampling edge.
    signal_in = 1'b0;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clock);
      chk("fall_pulse", falling_edge, c == LAT);
      chk("fall_any", edge_detected, c == LAT);
      chk("fall_norise", rising_edge, 1'b0);
    end

    // Rising pulse, then falling pulse HOLD cycles later.
    signal_in = 1'b1;
    for (int c = 1; c <= LAT + HOLD + 3; c++) begin
      @(negedge clock);
      if (c == HOLD) signal_in = 1'b0;
      chk("pair_rise", rising_edge, c == LAT);
      chk("pair_fall", falling_edge, c == LAT + HOLD);
    end

`ifdef EDGE_DETECTOR_GLITCH_FILTER_EN
    // Low glitch one cycle shorter than the filter: must vanish.
    signal_in = 1'b1;
    repeat (LAT + 4) @(negedge clock);
    signal_in = 1'b0;
    repeat (FLEN - 1) @(negedge clock);
    signal_in = 1'b1;
    quiet("glitch", 15);
`endif

    // Reset released with the bus low: one falling pulse, then quiet.
    reset_n = 1'b0;
    signal_in = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int c = 1; c <= LAT + 4; c++) begin
      @(negedge clock);
      chk("rstlow_fall", falling_edge, c == LAT);
      chk("rstlow_rise", rising_edge, 1'b0);
    end

    // Reset one cycle after an input change discards the pending edge.
    signal_in = 1'b1;
    repeat (LAT + FLEN + 2) @(negedge clock);
    signal_in = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    signal_in = 1'b1;
    quiet("midrst_hold", 3);
    reset_n = 1'b1;
    quiet("midrst_after", 10);

    // Randomized runs with occasional short resets; model checks every cycle.
    lv = 1'b1;
    run = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clock);
      if (run == 0) begin
        lv = ~lv;
        run = $urandom_range(1, 7);
      end
      run--;
      signal_in = lv;
      reset_n = ($urandom_range(0, 249) != 0);
    end
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
